// File: rtl/twi_regfile_pkg.sv
// Shared types and constants for the TWI register bank: FSM encoding,
// special read index, default register values and an index-range helper.
package twi_regfile_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CAPTURE  = 2'd1,
    ST_COMMIT   = 2'd2,
    ST_WAIT_LOW = 2'd3
  } state_t;

  localparam logic [7:0] ID_INDEX       = 8'hFF;
  localparam logic [7:0] DEF_ID_VALUE   = 8'hA5;
  localparam logic [7:0] DEF_CTRL_RESET = 8'h00;

  function automatic logic idx_below(input logic [7:0] idx, input int unsigned limit);
    return 32'(idx) < limit;
  endfunction

endpackage

// File: rtl/twi_strobe_sync.sv
// Three-flop synchronizer for an SCL-domain pulse: o_level is the synchronized
// level, o_rise a one-cycle pulse on its rising edge.
module twi_strobe_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;
  logic r_warm;
  logic r_armed;

  // A strobe already high when reset is released must not count as a new
  // edge, so rises are only honoured once the input has been seen low.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_s3    <= 1'b0;
      r_warm  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_s1   <= i_async;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_warm <= 1'b1;
      if (r_warm && !r_s1) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign o_level = r_s2;
  assign o_rise  = r_s2 & ~r_s3 & r_armed;

endmodule

// File: rtl/twi_regfile.sv
// System-clock register bank behind the TWI slave: synchronizes the write
// strobe, commits control writes and serves reads. Watchdog: TWI_REGFILE_WDT_EN.
module twi_regfile
  import twi_regfile_pkg::*;
#(
  parameter int          NUM_CTRL   = 8,
  parameter int          NUM_STAT   = 4,
  parameter logic [7:0]  CTRL_RESET = DEF_CTRL_RESET,
  parameter logic [7:0]  ID_VALUE   = DEF_ID_VALUE,
  parameter logic [23:0] WDT_CYCLES = 24'd5_000_000
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [7:0]            i_twi_addr,
  input  logic [7:0]            i_twi_data_in,
  input  logic                  i_twi_data_in_clk,
  output logic [7:0]            o_twi_data_out,
  input  logic [NUM_STAT*8-1:0] i_status_in,
  output logic [NUM_CTRL*8-1:0] o_ctrl_out,
  output logic                  o_wr_stb,
  output logic [7:0]            o_wr_idx,
  output logic                  o_wdt_expired
);

  state_t     r_state;
  state_t     w_state_next;
  logic       w_level;
  logic       w_rise;
  logic       w_capture;
  logic       w_commit;
  logic       w_wdt_fire;
  logic [7:0] r_idx_h;
  logic [7:0] r_data_h;
  logic [7:0] r_ctrl [NUM_CTRL];
  logic       r_wr_stb;
  logic [7:0] r_wr_idx;
  logic [7:0] r_addr_q;
  logic [7:0] r_rd_data;
  logic [7:0] w_rd_mux;

  twi_strobe_sync u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_async (i_twi_data_in_clk),
    .o_level (w_level),
    .o_rise  (w_rise)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // The commit is registered on the CAPTURE->COMMIT edge, so ctrl_out and
  // wr_stb are visible throughout the COMMIT cycle.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_commit     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_capture    = 1'b1;
          w_state_next = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        w_commit     = idx_below(r_idx_h, NUM_CTRL);
        w_state_next = ST_COMMIT;
      end
      ST_COMMIT: begin
        w_state_next = ST_WAIT_LOW;
      end
      ST_WAIT_LOW: begin
        if (!w_level) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx_h  <= 8'h00;
      r_data_h <= 8'h00;
    end else if (w_capture) begin
      r_idx_h  <= i_twi_addr;
      r_data_h <= i_twi_data_in;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_stb <= 1'b0;
      r_wr_idx <= 8'h00;
    end else begin
      r_wr_stb <= w_commit;
      if (w_commit) begin
        r_wr_idx <= r_idx_h;
      end
    end
  end

  assign o_wr_stb = r_wr_stb;
  assign o_wr_idx = r_wr_idx;

  // A write in the same cycle as a watchdog expiry takes priority.
  for (genvar gi = 0; gi < NUM_CTRL; gi++) begin : g_ctrl
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_ctrl[gi] <= CTRL_RESET;
      end else if (w_commit && (r_idx_h == 8'(gi))) begin
        r_ctrl[gi] <= r_data_h;
      end else if (w_wdt_fire) begin
        r_ctrl[gi] <= CTRL_RESET;
      end
    end
    assign o_ctrl_out[gi*8 +: 8] = r_ctrl[gi];
  end

  always_comb begin
    w_rd_mux = 8'h00;
    for (int k = 0; k < NUM_CTRL; k++) begin
      if (r_addr_q == 8'(k)) begin
        w_rd_mux = r_ctrl[k];
      end
    end
    for (int k = 0; k < NUM_STAT; k++) begin
      if (r_addr_q == 8'(NUM_CTRL + k)) begin
        w_rd_mux = i_status_in[k*8 +: 8];
      end
    end
    if (r_addr_q == ID_INDEX) begin
      w_rd_mux = ID_VALUE;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr_q  <= 8'h00;
      r_rd_data <= 8'h00;
    end else begin
      r_addr_q  <= i_twi_addr;
      r_rd_data <= w_rd_mux;
    end
  end

  assign o_twi_data_out = r_rd_data;

`ifdef TWI_REGFILE_WDT_EN
  localparam logic [23:0] WDT_LAST = WDT_CYCLES - 24'd1;

  logic [23:0] r_wdt_cnt;
  logic        r_wdt_exp;

  // The counter parks at WDT_LAST, so the reset load repeats until a write.
  assign w_wdt_fire = (r_wdt_cnt == WDT_LAST) && !w_commit;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wdt_cnt <= 24'd0;
      r_wdt_exp <= 1'b0;
    end else if (w_commit) begin
      r_wdt_cnt <= 24'd0;
      r_wdt_exp <= 1'b0;
    end else if (r_wdt_cnt == WDT_LAST) begin
      r_wdt_exp <= 1'b1;
    end else begin
      r_wdt_cnt <= r_wdt_cnt + 24'd1;
    end
  end

  assign o_wdt_expired = r_wdt_exp;
`else
  logic w_unused_wdt;

  assign w_wdt_fire    = 1'b0;
  assign o_wdt_expired = 1'b0;
  assign w_unused_wdt  = ^WDT_CYCLES;
`endif

endmodule

// File: tb/tb_twi_regfile.sv
// Scoreboard bench for twi_regfile: directed cases plus randomized writes and
// reads against an array-based reference model (watchdog cases under TWI_REGFILE_WDT_EN).
module tb_twi_regfile;

  localparam int         NC    = 8;
  localparam int         NS    = 4;
  localparam logic [7:0] CR    = 8'h00;
  localparam logic [7:0] IDV   = 8'hA5;
  localparam int         WDT_N = 100;
`ifdef TWI_REGFILE_WDT_EN
  localparam bit WDT_ON = 1'b1;
`else
  localparam bit WDT_ON = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [7:0]      twi_addr = 8'h00;
  logic [7:0]      twi_din = 8'h00;
  logic            twi_stb = 1'b0;
  logic [7:0]      twi_dout;
  logic [NS*8-1:0] status_in = '0;
  logic [NC*8-1:0] ctrl_out;
  logic            wr_stb;
  logic [7:0]      wr_idx;
  logic            wdt_expired;

  always #5 clk = ~clk;

  twi_regfile #(
    .NUM_CTRL   (NC),
    .NUM_STAT   (NS),
    .CTRL_RESET (CR),
    .ID_VALUE   (IDV),
    .WDT_CYCLES (24'(WDT_N))
  ) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_twi_addr        (twi_addr),
    .i_twi_data_in     (twi_din),
    .i_twi_data_in_clk (twi_stb),
    .o_twi_data_out    (twi_dout),
    .i_status_in       (status_in),
    .o_ctrl_out        (ctrl_out),
    .o_wr_stb          (wr_stb),
    .o_wr_idx          (wr_idx),
    .o_wdt_expired     (wdt_expired)
  );

  typedef struct {
    logic [7:0] idx;
    logic [7:0] data;
    int         rise;
  } wr_t;

  typedef struct {
    logic [7:0] exp;
    int         due;
    logic [7:0] addr;
  } rd_t;

  wr_t        wq[$];
  rd_t        rq[$];
  logic [7:0] m_ctrl [NC];
  bit         m_expired = 1'b0;
  int         last_commit = 0;
  int         stb_count = 0;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [NC*8-1:0] model_ctrl();
    logic [NC*8-1:0] v;
    for (int k = 0; k < NC; k++) v[k*8 +: 8] = m_ctrl[k];
    return v;
  endfunction

  function automatic logic [7:0] model_read(input logic [7:0] a);
    int ai;
    ai = int'(a);
    if (ai < NC) return m_ctrl[ai];
    if (ai < NC + NS) return status_in[(ai - NC)*8 +: 8];
    if (a == 8'hFF) return IDV;
    return 8'h00;
  endfunction

  // Monitor: retires expected writes on wr_stb, applies watchdog expiry to
  // the model, and checks reads when their data is due.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NC; k++) m_ctrl[k] = CR;
      m_expired   = 1'b0;
      last_commit = cyc;
    end else begin
      if (wr_stb) begin
        stb_count++;
        if (wq.size() == 0) begin
          check("unexpected_wr_stb", {56'd0, wr_idx}, 64'hFFFF);
        end else begin
          wr_t w;
          w = wq.pop_front();
          check("wr_idx", {56'd0, wr_idx}, {56'd0, w.idx});
          check("wr_latency", 64'(cyc - w.rise), 64'd4);
          m_ctrl[int'(w.idx)] = w.data;
          last_commit = cyc;
          m_expired   = 1'b0;
          check("ctrl_after_write", ctrl_out, model_ctrl());
        end
      end
      if (WDT_ON && !m_expired && (cyc - last_commit >= WDT_N)) begin
        m_expired = 1'b1;
        for (int k = 0; k < NC; k++) m_ctrl[k] = CR;
      end
      if (rq.size() != 0 && rq[0].due == cyc) begin
        rd_t r;
        r = rq.pop_front();
        check($sformatf("read_%02h", r.addr), {56'd0, twi_dout}, {56'd0, r.exp});
      end
    end
  end

  task automatic do_write(input logic [7:0] idx, input logic [7:0] data, input int len);
    @(negedge clk);
    twi_addr = idx;
    twi_din  = data;
    repeat (2) @(negedge clk);
    twi_stb = 1'b1;
    if (int'(idx) < NC) wq.push_back('{idx: idx, data: data, rise: cyc});
    repeat (len) @(negedge clk);
    twi_stb = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic do_read(input logic [7:0] a);
    @(negedge clk);
    twi_addr = a;
    rq.push_back('{exp: model_read(a), due: cyc + 2, addr: a});
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int  s0;
    bit  seen;
    #1000000;
    $display("[TB] FAIL global_timeout: simulation still running at cycle %0d, expected finish", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int s0;
    bit seen;
    status_in = 32'h0000_7E00;
    repeat (3) @(negedge clk);
    check("rst_ctrl_out", ctrl_out, {NC{CR}});
    check("rst_data_out", {56'd0, twi_dout}, 64'd0);
    check("rst_wr_stb", {63'd0, wr_stb}, 64'd0);
    check("rst_wr_idx", {56'd0, wr_idx}, 64'd0);
    check("rst_wdt", {63'd0, wdt_expired}, 64'd0);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);

    s0 = stb_count;
    do_write(8'd2, 8'h3C, 10);
    check("single_write_pulses", 64'(stb_count - s0), 64'd1);
    check("ctrl_byte2", {56'd0, ctrl_out[2*8 +: 8]}, 64'h3C);

    s0 = stb_count;
    do_write(8'd0, 8'h11, 50);
    check("long_strobe_pulses", 64'(stb_count - s0), 64'd1);

    do_read(8'd9);
    do_read(8'hFF);
    do_read(8'h40);
    do_read(8'd2);

    s0 = stb_count;
    do_write(8'd9, 8'h55, 10);
    do_write(8'h40, 8'h55, 10);
    do_write(8'hFF, 8'h55, 10);
    check("dropped_write_pulses", 64'(stb_count - s0), 64'd0);
    check("dropped_write_ctrl", ctrl_out, model_ctrl());

    // Reset during COMMIT of a write, with the strobe still high afterwards.
    @(negedge clk);
    twi_addr = 8'd1;
    twi_din  = 8'hFF;
    repeat (2) @(negedge clk);
    twi_stb = 1'b1;
    wq.push_back('{idx: 8'd1, data: 8'hFF, rise: cyc});
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      #2;
      if (wr_stb) seen = 1'b1;
    end
    check("reset_test_commit_seen", {63'd0, seen}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_ctrl", ctrl_out, {NC{CR}});
    check("async_reset_wr_stb", {63'd0, wr_stb}, 64'd0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    s0 = stb_count;
    repeat (15) @(negedge clk);
    twi_stb = 1'b0;
    repeat (6) @(negedge clk);
    check("no_stb_after_reset", 64'(stb_count - s0), 64'd0);
    check("ctrl_after_reset", ctrl_out, {NC{CR}});

    if (WDT_ON) begin
      do_write(8'd3, 8'h80, 10);
      repeat (WDT_N + 5) @(negedge clk);
      check("wdt_byte3", {56'd0, ctrl_out[3*8 +: 8]}, 64'h00);
      check("wdt_expired_set", {63'd0, wdt_expired}, 64'd1);
      do_write(8'd0, 8'h01, 10);
      check("wdt_expired_clr", {63'd0, wdt_expired}, 64'd0);
      check("wdt_byte0", {56'd0, ctrl_out[7:0]}, 64'h01);
      check("wdt_ctrl_all", ctrl_out, model_ctrl());
    end else begin
      repeat (WDT_N + 20) @(negedge clk);
      check("no_wdt_expired", {63'd0, wdt_expired}, 64'd0);
      check("no_wdt_ctrl_hold", ctrl_out, model_ctrl());
    end

    for (int it = 0; it < 40; it++) begin
      logic [7:0] idx;
      logic [7:0] ra;
      if (!WDT_ON && $urandom_range(0, 3) == 0) idx = 8'($urandom_range(0, 255));
      else idx = 8'($urandom_range(0, NC - 1));
      do_write(idx, 8'($urandom), $urandom_range(6, 25));
      @(negedge clk);
      status_in = $urandom;
      ra = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 15));
      do_read(ra);
      do_read(idx);
    end

    repeat (10) @(negedge clk);
    check("write_queue_drained", 64'(wq.size()), 64'd0);
    check("read_queue_drained", 64'(rq.size()), 64'd0);
    check("final_ctrl", ctrl_out, model_ctrl());

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
